// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner for a stopwatch display.
// Snapshots digit patterns per frame, adds dark guard gaps, leading-zero blanking and frame-based blink.
module seg7_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD_CYC    = 16,
  parameter int BLINK_FRAMES = 62
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] sec1,
  input  logic [6:0] sec2,
  input  logic [6:0] min1,
  input  logic [6:0] min2,
  input  logic       tick,
  input  logic       blank_lz,
  input  logic       blink,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       frame_done
);

  typedef enum logic [1:0] {S_OFF, S_SHOW, S_GUARD} state_t;

  localparam logic [6:0]  SEG_DARK   = 7'h7F;
  localparam logic [6:0]  SEG_ZERO   = 7'b0000001;
  localparam logic [15:0] SHOW_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYC - 1);
  localparam logic [7:0]  FRAME_LAST = 8'(BLINK_FRAMES - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [1:0]  r_idx;
  logic [7:0]  r_fcnt;
  logic        r_ph;
  logic [6:0]  r_snap [4];

  state_t      w_nxt_state;
  logic [15:0] w_nxt_cnt;
  logic [1:0]  w_nxt_idx;
  logic [7:0]  w_nxt_fcnt;
  logic        w_nxt_ph;
  logic        w_load;
  logic        w_frame_end;
  logic [6:0]  w_nxt_snap [4];
  logic [6:0]  w_pat;
  logic        w_lz_blank;
  logic        w_lit;
  logic [3:0]  w_an;
  logic [6:0]  w_seg;
  logic        w_dp;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_idx   = r_idx;
    w_nxt_fcnt  = r_fcnt;
    w_nxt_ph    = r_ph;
    w_load      = 1'b0;
    w_frame_end = 1'b0;
    if (!en) begin
      w_nxt_state = S_OFF;
      w_nxt_cnt   = '0;
      w_nxt_idx   = '0;
      w_nxt_fcnt  = '0;
      w_nxt_ph    = 1'b0;
    end else begin
      unique case (r_state)
        S_OFF: begin
          w_nxt_state = S_SHOW;
          w_nxt_cnt   = '0;
          w_nxt_idx   = '0;
          w_load      = 1'b1;
        end
        S_SHOW: begin
          if (r_cnt == SHOW_LAST) begin
            w_nxt_cnt   = '0;
            w_nxt_state = S_GUARD;
          end else begin
            w_nxt_cnt = r_cnt + 16'd1;
          end
        end
        S_GUARD: begin
          if (r_cnt == GUARD_LAST) begin
            w_nxt_cnt   = '0;
            w_nxt_state = S_SHOW;
            w_nxt_idx   = r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              // Frame boundary: fresh snapshot so a digit never changes mid-frame.
              w_frame_end = 1'b1;
              w_load      = 1'b1;
              if (r_fcnt == FRAME_LAST) begin
                w_nxt_fcnt = '0;
                w_nxt_ph   = ~r_ph;
              end else begin
                w_nxt_fcnt = r_fcnt + 8'd1;
              end
            end
          end else begin
            w_nxt_cnt = r_cnt + 16'd1;
          end
        end
        default: w_nxt_state = S_OFF;
      endcase
    end

    w_nxt_snap[0] = w_load ? sec1 : r_snap[0];
    w_nxt_snap[1] = w_load ? sec2 : r_snap[1];
    w_nxt_snap[2] = w_load ? min1 : r_snap[2];
    w_nxt_snap[3] = w_load ? min2 : r_snap[3];

    // Outputs are derived from the next state so the registered pins line up with the state they describe.
    w_pat      = w_nxt_snap[w_nxt_idx];
    w_lz_blank = blank_lz && (w_nxt_idx == 2'd3) && (w_pat == SEG_ZERO);
    w_lit      = (w_nxt_state == S_SHOW) && !w_lz_blank && !(blink && w_nxt_ph);
    w_an       = w_lit ? ~(4'b0001 << w_nxt_idx) : 4'hF;
    w_seg      = w_lit ? w_pat : SEG_DARK;
    w_dp       = !(w_lit && (w_nxt_idx == 2'd2) && tick);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the four snapshot entries are plain flops, so resetting them is cheap and keeps outputs defined.
      r_state    <= S_OFF;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_fcnt     <= '0;
      r_ph       <= 1'b0;
      r_snap     <= '{default: SEG_DARK};
      an         <= 4'hF;
      seg        <= SEG_DARK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      r_state    <= w_nxt_state;
      r_cnt      <= w_nxt_cnt;
      r_idx      <= w_nxt_idx;
      r_fcnt     <= w_nxt_fcnt;
      r_ph       <= w_nxt_ph;
      r_snap     <= w_nxt_snap;
      an         <= w_an;
      seg        <= w_seg;
      dp         <= w_dp;
      frame_done <= w_frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomised self-checking bench for seg7_scan_ctrl against a time-based frame model.
// Expected outputs come from the position within the frame, computed arithmetically.
module tb_seg7_scan_ctrl;

  localparam int SD     = 4;
  localparam int GC     = 1;
  localparam int BF     = 2;
  localparam int SLOT   = SD + GC;
  localparam int PERIOD = 4 * SLOT;

  localparam logic [6:0] ZERO = 7'b0000001;
  localparam logic [6:0] DARK = 7'h7F;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [6:0] sec1 = ZERO, sec2 = ZERO, min1 = ZERO, min2 = ZERO;
  logic       tick = 1'b0, blank_lz = 1'b0, blink = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: cycles since the scan started (-1 when off) and per-frame snapshot.
  int         m_t = -1;
  logic [6:0] m_snap [4];
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  logic       e_fd;

  int cyc = 0;
  int last_fd = -1;

  seg7_scan_ctrl #(.SCAN_DIV(SD), .GUARD_CYC(GC), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .en(en),
    .sec1(sec1), .sec2(sec2), .min1(min1), .min2(min2),
    .tick(tick), .blank_lz(blank_lz), .blink(blink),
    .seg(seg), .an(an), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_update();
    int p, digit, frame;
    bit lit;
    if (!rst || !en) begin
      m_t = -1;
      if (!rst) m_snap = '{default: DARK};
    end else begin
      m_t++;
      if (m_t % PERIOD == 0) m_snap = '{sec1, sec2, min1, min2};
    end
    e_an = 4'hF; e_seg = DARK; e_dp = 1'b1; e_fd = 1'b0;
    if (m_t >= 0) begin
      p     = m_t % PERIOD;
      frame = m_t / PERIOD;
      digit = p / SLOT;
      lit   = (p % SLOT) < SD;
      e_fd  = (p == 0) && (m_t > 0);
      if (blink && ((frame / BF) % 2 == 1)) lit = 0;
      if (digit == 3 && blank_lz && m_snap[3] == ZERO) lit = 0;
      if (lit) begin
        e_an  = 4'hF;
        e_an[digit] = 1'b0;
        e_seg = m_snap[digit];
        e_dp  = !(digit == 2 && tick);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
    check("an", an, e_an);
    check("seg", seg, e_seg);
    check("dp", dp, e_dp);
    check("frame_done", frame_done, e_fd);
    check("an_one_low", ($countones(~an) <= 1), 1);
    if (m_t < 0) last_fd = -1;
    if (frame_done) begin
      if (last_fd >= 0) check("frame_period", cyc - last_fd, PERIOD);
      last_fd = cyc;
    end
  endtask

  function automatic logic [6:0] rand_pat();
    return ($urandom_range(0, 3) == 0) ? ZERO : 7'($urandom());
  endfunction

  initial begin
    m_snap = '{default: DARK};
    // Reset holds everything dark even with en asserted.
    en = 1'b1;
    repeat (3) step();

    // Basic scan order with sec1 showing a '1', tick drives dp on min1.
    rst = 1'b1;
    sec1 = 7'b1001111;
    tick = 1'b1;
    repeat (45) step();
    tick = 1'b0;
    repeat (20) step();

    // Mid-frame change must wait for the next frame boundary.
    repeat (7) step();
    sec1 = 7'b0010010;
    repeat (40) step();

    // Leading-zero blank on min2, then shown again.
    blank_lz = 1'b1;
    repeat (40) step();
    blank_lz = 1'b0;
    repeat (20) step();

    // Blink: two frames lit, two dark, repeating.
    blink = 1'b1;
    repeat (100) step();
    blink = 1'b0;

    // Abort by en mid-SHOW, then restart.
    repeat (2) step();
    en = 1'b0;
    repeat (2) step();
    en = 1'b1;
    repeat (30) step();

    // Abort by reset mid-frame.
    repeat (3) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (30) step();

    // Random traffic on all inputs.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) sec1 = rand_pat();
      if ($urandom_range(0, 19) == 0) sec2 = rand_pat();
      if ($urandom_range(0, 19) == 0) min1 = rand_pat();
      if ($urandom_range(0, 19) == 0) min2 = rand_pat();
      if ($urandom_range(0, 7) == 0) tick = ~tick;
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 79) == 0) blink = ~blink;
      en  = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles each digit is lit (legal 2..65535).
REQ-002 SHALL have parameter GUARD_CYC, default 16, all-dark cycles between digits (legal 1..SCAN_DIV-1).
REQ-003 SHALL have parameter BLINK_FRAMES, default 62, frames per blink half-period (legal 1..255).
REQ-004 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port en  in  1  scan enable; 0 forces display off.
REQ-007 SHALL have ports sec1, sec2, min1, min2  in  7 each  active-low segment patterns a..g (MSB=a); 7'b0000001 is the zero pattern.
REQ-008 SHALL have port tick  in  1  seconds tick level from the stopwatch; drives dp.
REQ-009 SHALL have port blank_lz  in  1  leading-zero blank enable for min2.
REQ-010 SHALL have port blink  in  1  blink enable (paused indication).
REQ-011 SHALL have port seg  out  7  shared active-low segment bus.
REQ-012 SHALL have port an  out  4  active-low digit enables; an[0]=sec1, an[1]=sec2, an[2]=min1, an[3]=min2.
REQ-013 SHALL have port dp  out  1  active-low decimal point.
REQ-014 SHALL have port frame_done  out  1  one-cycle pulse at end of each 4-digit frame.

Function
REQ-015 SHALL implement FSM states OFF, SHOW, GUARD plus 2-bit digit index idx, 16-bit slot counter cnt, 8-bit frame counter fcnt, blink phase bit ph.
REQ-016 SHALL, in OFF: an=4'b1111, seg=7'h7F, dp=1, cnt=0, idx=0; when en=1, go to SHOW with idx=0 and snapshot all four digit inputs next edge.
REQ-017 SHALL, in SHOW: cnt increments each cycle; at cnt==SCAN_DIV-1 clear cnt and go to GUARD.
REQ-018 SHALL, in GUARD: an=4'b1111, seg=7'h7F, dp=1; cnt increments; at cnt==GUARD_CYC-1 clear cnt, idx=idx+1 mod 4, go to SHOW.
REQ-019 SHALL, on GUARD exit with idx==3: pulse frame_done for exactly one cycle, wrap idx to 0, re-snapshot sec1..min2 (no mid-frame tearing).
REQ-020 SHALL, in SHOW: an = one-hot-low at idx, seg = snapshot pattern of digit idx.
REQ-021 SHALL drive dp=0 only in SHOW with idx==2 and tick=1 (sampled live), else 1.
REQ-022 SHALL, when blank_lz=1 and min2 snapshot==7'b0000001, hold an[3]=1 and seg=7'h7F during the idx==3 SHOW slot; slot timing unchanged.
REQ-023 SHALL count frames in fcnt; at frame_done with fcnt==BLINK_FRAMES-1 clear fcnt and toggle ph; else fcnt+1.
REQ-024 SHALL, when blink=1 and ph=1, force an=4'b1111, seg=7'h7F, dp=1 in SHOW; counters and timing unchanged; blink=0 ignores ph.
REQ-025 SHALL register all outputs; outputs reflect the current FSM state (no combinational path from inputs except via registers).
REQ-026 SHALL, when en=0 in any state, enter OFF on the next edge, clear cnt, idx, fcnt, ph; frame_done not asserted.
REQ-027 SHALL give frame period exactly 4*(SCAN_DIV+GUARD_CYC) cycles while en=1.
REQ-028 SHALL never assert more than one an bit low in any cycle.

Reset
REQ-029 SHALL, on rising clk with rst=0, set state=OFF, cnt=0, idx=0, fcnt=0, ph=0, snapshots=7'h7F.
REQ-030 SHALL reset outputs to an=4'b1111, seg=7'h7F, dp=1, frame_done=0; reset mid-frame aborts without any extra pulse.
REQ-031 SHALL take reset precedence over en and all other inputs.

Verification (SCAN_DIV=4, GUARD_CYC=1, BLINK_FRAMES=2)
REQ-032 Scan order: rst released, en=1, sec1=7'b1001111, others zero pattern -> an sequence 1110,1111,1101,1111,1011,1111,0111,1111, each lit 4 cycles, dark 1; seg=7'b1001111 during an=1110; frame_done pulse every 20 cycles.
REQ-033 Snapshot: change sec1 mid-frame -> seg for digit 0 updates only in the frame after next frame_done.
REQ-034 Leading zero: blank_lz=1, min2=7'b0000001 -> an[3] never low; blank_lz=0 -> an=0111 with seg=7'b0000001.
REQ-035 Blink: blink=1 -> 2 frames lit, 2 frames fully dark (an=1111), repeating; frame_done still every 20 cycles.
REQ-036 dp/tick: tick=1 -> dp=0 only during an=1011 slots; tick=0 -> dp stays 1.
REQ-037 Abort: en=0 or rst=0 mid-SHOW -> next cycle an=1111, seg=7'h7F; re-enable restarts at idx 0 with full 4-cycle slot.
